instr_mem_loader: RTL and testbench

Parametrised instruction memory for the single-cycle RISC-V core. It replaces fixed, hard-wired program contents with three things: a sequential load port, a hardware clear sweep after reset, and a registered fetch port with alignment and range fault detection. The block sits between the program source (testbench or boot loader) and the core's fetch stage. Accesses use byte addresses on a word-organised array.

---
 rtl/instr_mem_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: word-organised instruction memory for the single-cycle
// RISC-V core. After reset it sweeps FILL_WORD into every word. It then
// accepts a program through a sequential load port and finally serves
// registered, byte-addressed fetches with alignment and range fault detection.
module instr_mem_loader #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = 'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [DATA_W-1:0]          ld_data,
  input  logic                       ld_last,
  output logic [$clog2(DEPTH+1)-1:0] ld_count,
  input  logic                       reload,
  input  logic                       fetch_req,
  output logic                       fetch_ready,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_fault,
  output logic                       busy,
  output logic                       loaded
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WIW = ADDR_W - 2;

  localparam logic [AW-1:0]  LAST_IDX    = AW'(DEPTH - 1);
  localparam logic [WIW-1:0] DEPTH_WORDS = WIW'(DEPTH);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e state_q;

  logic [AW-1:0]     clr_ptr_q;
  logic [AW-1:0]     ld_ptr_q;
  logic [CW-1:0]     ld_count_q;
  logic              ld_ready_q;
  logic              fetch_ready_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] fetch_instr_q;
  logic              fetch_fault_q;
  logic              busy_q;
  logic              loaded_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              ld_accept;
  logic              fetch_accept;
  logic [WIW-1:0]    fetch_word_idx;
  logic              fetch_fault_d;
  logic [DATA_W-1:0] fetch_instr_d;

  assign ld_accept      = ld_valid && ld_ready_q;
  assign fetch_accept   = fetch_req && fetch_ready_q;
  assign fetch_word_idx = fetch_addr[ADDR_W-1:2];

  // Fetch response: fill word plus fault flag for misaligned or out-of-range addresses.
  always_comb begin
    fetch_fault_d = (fetch_addr[1:0] != 2'b00) || (fetch_word_idx >= DEPTH_WORDS);
    fetch_instr_d = FILL_WORD;
    if (!fetch_fault_d) begin
      fetch_instr_d = mem[fetch_word_idx[AW-1:0]];
    end
  end

  // Array write port: the clear sweep writes fill words, the load port writes program
  // words, and nothing is written while reset is held.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = FILL_WORD;
    if (reset) begin
      if (state_q == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if ((state_q == ST_LOAD) && ld_accept) begin
        mem_we    = 1'b1;
        mem_waddr = ld_ptr_q;
        mem_wdata = ld_data;
      end
    end
  end

  // Storage array. It has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered status outputs and the fetch response pipeline stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      ld_ptr_q      <= '0;
      ld_count_q    <= '0;
      ld_ready_q    <= 1'b0;
      fetch_ready_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= 1'b0;
      busy_q        <= 1'b1;
      loaded_q      <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_accept;
      if (fetch_accept) begin
        fetch_instr_q <= fetch_instr_d;
        fetch_fault_q <= fetch_fault_d;
      end

      case (state_q)
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + AW'(1);
          if (clr_ptr_q == LAST_IDX) begin
            state_q    <= ST_LOAD;
            clr_ptr_q  <= '0;
            ld_ptr_q   <= '0;
            ld_count_q <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (ld_accept) begin
            ld_ptr_q   <= ld_ptr_q + AW'(1);
            ld_count_q <= ld_count_q + CW'(1);
            if (ld_last || (ld_ptr_q == LAST_IDX)) begin
              state_q       <= ST_RUN;
              ld_ready_q    <= 1'b0;
              fetch_ready_q <= 1'b1;
              loaded_q      <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (reload) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            ld_count_q    <= '0;
            loaded_q      <= 1'b0;
            fetch_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign ld_ready    = ld_ready_q;
  assign ld_count    = ld_count_q;
  assign fetch_ready = fetch_ready_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign busy        = busy_q;
  assign loaded      = loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed, table-driven bench for instr_mem_loader with
// DEPTH=64. It covers the clear sweep, program load, fetch and fault vectors,
// overflow truncation, reload with a simultaneous fetch, and reset during
// operation.
module tb_instr_mem_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [31:0] FILL = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } fetch_vec_t;

  logic              clk;
  logic              reset;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic [CW-1:0]     ld_count;
  logic              reload;
  logic              fetch_req;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_fault;
  logic              busy;
  logic              loaded;

  int checks = 0;
  int errors = 0;

  fetch_vec_t vecs [9];

  instr_mem_loader #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .FILL_WORD(FILL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_count   (ld_count),
    .reload     (reload),
    .fetch_req  (fetch_req),
    .fetch_ready(fetch_ready),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .busy       (busy),
    .loaded     (loaded)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ld_ready"},    32'(ld_ready),    32'd0);
    checkOutput({tag, " fetch_ready"}, 32'(fetch_ready), 32'd0);
    checkOutput({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    checkOutput({tag, " fetch_instr"}, fetch_instr,      32'd0);
    checkOutput({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
    checkOutput({tag, " ld_count"},    32'(ld_count),    32'd0);
    checkOutput({tag, " loaded"},      32'(loaded),      32'd0);
    checkOutput({tag, " busy"},        32'(busy),        32'd1);
  endtask

  // Called on the negedge just after CLEAR was entered (or reset released);
  // checks each of the following DEPTH sweep edges.
  task automatic waitSweep(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      checkOutput({tag, " busy"},        32'(busy),        32'(i < DEPTH));
      checkOutput({tag, " ld_ready"},    32'(ld_ready),    32'(i == DEPTH));
      checkOutput({tag, " fetch_ready"}, 32'(fetch_ready), 32'd0);
      checkOutput({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    @(negedge clk);
  endtask

  task automatic applyFetch(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
  endtask

  task automatic fetchAndCheck(input string tag, input logic [31:0] addr,
                               input logic [31:0] instr, input logic fault);
    applyFetch(addr);
    checkOutput({tag, " valid"}, 32'(fetch_valid), 32'd1);
    checkOutput({tag, " instr"}, fetch_instr,      instr);
    checkOutput({tag, " fault"}, 32'(fetch_fault), 32'(fault));
  endtask

  // Main directed sequence.
  initial begin
    vecs[0] = '{addr: 32'h0000_0000, instr: 32'h0000_0013, fault: 1'b0};
    vecs[1] = '{addr: 32'h0000_0004, instr: 32'h0198_0633, fault: 1'b0};
    vecs[2] = '{addr: 32'h0000_0008, instr: 32'h0094_8663, fault: 1'b0};
    vecs[3] = '{addr: 32'h0000_000C, instr: FILL,          fault: 1'b0};
    vecs[4] = '{addr: 32'h0000_0002, instr: FILL,          fault: 1'b1};
    vecs[5] = '{addr: 32'h0000_0100, instr: FILL,          fault: 1'b1};
    vecs[6] = '{addr: 32'h0000_00FC, instr: FILL,          fault: 1'b0};
    vecs[7] = '{addr: 32'hFFFF_FFFC, instr: FILL,          fault: 1'b1};
    vecs[8] = '{addr: 32'h0000_0008, instr: 32'h0094_8663, fault: 1'b0};

    reset      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    reload     = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;

    repeat (2) @(negedge clk);
    checkResetOutputs("por");

    // Hold fetch_req, ld_valid and reload high through the sweep; all must be ignored.
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    ld_valid   = 1'b1;
    ld_data    = 32'hDEAD_BEEF;
    ld_last    = 1'b1;
    reload     = 1'b1;
    reset      = 1'b1;
    waitSweep("sweep0");
    fetch_req = 1'b0;
    ld_valid  = 1'b0;
    reload    = 1'b0;
    checkOutput("sweep0 ld_count", 32'(ld_count), 32'd0);
    checkOutput("sweep0 loaded",   32'(loaded),   32'd0);

    applyStimulus(32'h0000_0013, 1'b0);
    checkOutput("load1 ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("load1 ld_count", 32'(ld_count), 32'd1);
    checkOutput("load1 loaded",   32'(loaded),   32'd0);
    applyStimulus(32'h0198_0633, 1'b0);
    checkOutput("load2 ld_count", 32'(ld_count), 32'd2);
    applyStimulus(32'h0094_8663, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checkOutput("load3 ld_ready",    32'(ld_ready),    32'd0);
    checkOutput("load3 ld_count",    32'(ld_count),    32'd3);
    checkOutput("load3 loaded",      32'(loaded),      32'd1);
    checkOutput("load3 fetch_ready", 32'(fetch_ready), 32'd1);
    checkOutput("load3 busy",        32'(busy),        32'd0);

    for (int i = 0; i < 9; i++) begin
      fetchAndCheck($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].fault);
    end
    fetch_req = 1'b0;
    @(negedge clk);
    checkOutput("hold valid", 32'(fetch_valid), 32'd0);
    checkOutput("hold instr", fetch_instr,      vecs[8].instr);
    checkOutput("hold fault", 32'(fetch_fault), 32'(vecs[8].fault));
    checkOutput("run ld_count", 32'(ld_count),  32'd3);

    // Reload together with a fetch: response still delivered, state already CLEAR.
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    reload     = 1'b1;
    @(negedge clk);
    reload    = 1'b0;
    fetch_req = 1'b0;
    checkOutput("reload valid",       32'(fetch_valid), 32'd1);
    checkOutput("reload instr",       fetch_instr,      32'h0198_0633);
    checkOutput("reload fault",       32'(fetch_fault), 32'd0);
    checkOutput("reload busy",        32'(busy),        32'd1);
    checkOutput("reload loaded",      32'(loaded),      32'd0);
    checkOutput("reload fetch_ready", 32'(fetch_ready), 32'd0);
    checkOutput("reload ld_count",    32'(ld_count),    32'd0);
    waitSweep("sweep1");
    applyStimulus(32'hAAAA_0001, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checkOutput("reload1 loaded",   32'(loaded),   32'd1);
    checkOutput("reload1 ld_count", 32'(ld_count), 32'd1);
    fetchAndCheck("cleared w1", 32'h4, FILL, 1'b0);
    fetchAndCheck("new w0",     32'h0, 32'hAAAA_0001, 1'b0);
    fetch_req = 1'b0;

    // Overflow: 70 words without ld_last; only the first DEPTH are taken.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    waitSweep("sweep2");
    for (int i = 0; i < 70; i++) begin
      applyStimulus(32'h1000_0000 + 32'(i), 1'b0);
      checkOutput($sformatf("ovf%0d ld_count", i), 32'(ld_count),
                  32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
      checkOutput($sformatf("ovf%0d ld_ready", i), 32'(ld_ready), 32'(i < DEPTH - 1));
      checkOutput($sformatf("ovf%0d loaded", i),   32'(loaded),   32'(i >= DEPTH - 1));
    end
    ld_valid = 1'b0;
    fetchAndCheck("ovf last", 32'hFC, 32'h1000_003F, 1'b0);
    fetchAndCheck("ovf w0",   32'h00, 32'h1000_0000, 1'b0);
    fetchAndCheck("ovf w32",  32'h80, 32'h1000_0020, 1'b0);
    fetch_req = 1'b0;

    // Reset asserted in the middle of a load.
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    waitSweep("sweep3");
    applyStimulus(32'h1111_1111, 1'b0);
    applyStimulus(32'h2222_2222, 1'b0);
    ld_data = 32'h3333_3333;
    reset   = 1'b0;
    #1;
    checkResetOutputs("midload");
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    waitSweep("sweep4");
    checkOutput("post-reset ld_count", 32'(ld_count), 32'd0);
    checkOutput("post-reset ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("post-reset loaded",   32'(loaded),   32'd0);

    // Reset asserted while a fetch response is on the outputs.
    applyStimulus(32'h5555_0001, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetchAndCheck("pre-reset fetch", 32'h0, 32'h5555_0001, 1'b0);
    reset = 1'b0;
    #1;
    checkResetOutputs("midresp");
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
